// File: rtl/bridge_pkg.sv
// AHB-to-APB bridge shared definitions: FSM states, AHB transfer/response codes, slave-select width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WWAIT  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ENABLE = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  // Number of APB slaves; one-hot select is this wide.
  localparam int SEL_W = 4;

endpackage

// File: rtl/apb_bridge_ctrl_if.sv
// Bus bundle between the AHB side and the APB side of the bridge.
// Latency: n/a (wiring only).
// Backpressure: Hreadyout from the bridge stalls the AHB data phase.
// Ports: AHB inputs Hwrite/Hreadyin/Htrans/Haddr/Hwdata, AHB outputs Hreadyout/Hresp/Hrdata,
//        APB outputs Paddr/Pwdata/Pwrite/Pselx/Penable, APB input Prdata.
interface apb_bridge_ctrl_if;
  import bridge_pkg::*;

  logic             Hwrite;
  logic             Hreadyin;
  logic [1:0]       Htrans;
  logic [31:0]      Haddr;
  logic [31:0]      Hwdata;
  logic             Hreadyout;
  logic [1:0]       Hresp;
  logic [31:0]      Hrdata;
  logic [31:0]      Paddr;
  logic [31:0]      Pwdata;
  logic             Pwrite;
  logic [SEL_W-1:0] Pselx;
  logic             Penable;
  logic [31:0]      Prdata;

  // Bridge view: AHB slave, APB master.
  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    output Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Pselx, Penable
  );

  // Environment view: AHB master plus APB slaves.
  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    input  Hreadyout, Hresp, Hrdata, Paddr, Pwdata, Pwrite, Pselx, Penable
  );

endinterface

// File: rtl/apb_sel_decode.sv
// APB slave select decode: 2-bit slave index -> one-hot select.
// Latency: combinational.
// Backpressure: none.
// Ports: sel (index from address bits 27:26), onehot (SEL_W-bit select).
module apb_sel_decode
  import bridge_pkg::*;
(
  input  logic [1:0]       sel,
  output logic [SEL_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: converts qualified AHB transfers into APB setup/enable cycles.
// Latency: read data phase 2 cycles (SETUP, ENABLE); write data phase 3 cycles (WWAIT, SETUP, ENABLE).
// Backpressure: Hreadyout low in WWAIT and SETUP stalls the AHB data phase; APB slaves have no wait states.
// Ports: clk, Hreset (sync, active high), bus (AHB slave / APB master side of apb_bridge_ctrl_if).
module apb_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter logic [3:0] BASE_NIBBLE = 4'h8
) (
  input  logic            clk,
  input  logic            Hreset,
  apb_bridge_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic             latch_addr;
  logic             valid;
  logic [31:0]      paddr_q;
  logic [31:0]      pwdata_q;
  logic             pwrite_q;
  logic [SEL_W-1:0] sel_dec;

  // Only NONSEQ/SEQ transfers in our address window with the bus ready start an access.
  assign valid = bus.Hreadyin
               && ((bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ))
               && (bus.Haddr[31:28] == BASE_NIBBLE);

  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          latch_addr = 1'b1;
          state_nxt  = bus.Hwrite ? ST_WWAIT : ST_SETUP;
        end
      end
      ST_WWAIT:  state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ENABLE;
      ST_ENABLE: begin
        // Pipelined address phase overlaps ENABLE, so the next access follows without an IDLE gap.
        if (valid) begin
          latch_addr = 1'b1;
          state_nxt  = bus.Hwrite ? ST_WWAIT : ST_SETUP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Hreset) begin
      state    <= ST_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_addr) begin
        paddr_q  <= bus.Haddr;
        pwrite_q <= bus.Hwrite;
      end
      // Write data is only valid during the AHB data phase, which WWAIT covers.
      if (state == ST_WWAIT) begin
        pwdata_q <= bus.Hwdata;
      end
    end
  end

  apb_sel_decode u_sel_decode (
    .sel    (paddr_q[27:26]),
    .onehot (sel_dec)
  );

  // All APB outputs and Hreadyout come from registers only; Prdata->Hrdata is the one combinational path.
  assign bus.Hreadyout = (state == ST_IDLE) || (state == ST_ENABLE);
  assign bus.Hresp     = HRESP_OKAY;
  assign bus.Hrdata    = bus.Prdata;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Penable   = (state == ST_ENABLE);
  assign bus.Pselx     = ((state == ST_SETUP) || (state == ST_ENABLE)) ? sel_dec : '0;

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
module tb_apb_bridge_ctrl;
  import bridge_pkg::*;

  logic clk;
  logic Hreset;
  int   vectors;
  int   miscompares;

  apb_bridge_ctrl_if bus ();

  apb_bridge_ctrl #(.BASE_NIBBLE(4'h8)) dut (
    .clk    (clk),
    .Hreset (Hreset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the negedge, away from the active edge.
  task automatic addr_phase(input logic [31:0] addr, input logic wr,
                            input logic [1:0] trans, input logic rdy);
    bus.Haddr    = addr;
    bus.Hwrite   = wr;
    bus.Htrans   = trans;
    bus.Hreadyin = rdy;
  endtask

  task automatic bus_idle();
    addr_phase(32'h0, 1'b0, HTRANS_IDLE, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    bus_idle();
    bus.Hwdata = 32'h0;
    bus.Prdata = 32'h0;
    step();
    step();
    vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL rst_hready got %b want 1", bus.Hreadyout); end
    vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL rst_psel got %b want 0000", bus.Pselx); end
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL rst_penable got %b want 0", bus.Penable); end
    vectors++; if (bus.Paddr !== 32'h0) begin miscompares++; $display("FAIL rst_paddr got %h want 0", bus.Paddr); end
    vectors++; if (bus.Pwdata !== 32'h0) begin miscompares++; $display("FAIL rst_pwdata got %h want 0", bus.Pwdata); end
    vectors++; if (bus.Pwrite !== 1'b0) begin miscompares++; $display("FAIL rst_pwrite got %b want 0", bus.Pwrite); end
    vectors++; if (bus.Hresp !== 2'b00) begin miscompares++; $display("FAIL rst_hresp got %b want 00", bus.Hresp); end
    Hreset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    addr_phase(32'h8000_0010, 1'b1, HTRANS_NONSEQ, 1'b1);
    step();
    // WWAIT
    bus_idle();
    bus.Hwdata = 32'hDEAD_BEEF;
    vectors++; if (bus.Hreadyout !== 1'b0) begin miscompares++; $display("FAIL wr_wwait_hready got %b want 0", bus.Hreadyout); end
    vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL wr_wwait_psel got %b want 0000", bus.Pselx); end
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL wr_wwait_penable got %b want 0", bus.Penable); end
    step();
    // SETUP
    bus.Hwdata = 32'h0;
    vectors++; if (bus.Hreadyout !== 1'b0) begin miscompares++; $display("FAIL wr_setup_hready got %b want 0", bus.Hreadyout); end
    vectors++; if (bus.Pselx !== 4'b0001) begin miscompares++; $display("FAIL wr_setup_psel got %b want 0001", bus.Pselx); end
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL wr_setup_penable got %b want 0", bus.Penable); end
    vectors++; if (bus.Paddr !== 32'h8000_0010) begin miscompares++; $display("FAIL wr_setup_paddr got %h want 80000010", bus.Paddr); end
    vectors++; if (bus.Pwrite !== 1'b1) begin miscompares++; $display("FAIL wr_setup_pwrite got %b want 1", bus.Pwrite); end
    vectors++; if (bus.Pwdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_setup_pwdata got %h want deadbeef", bus.Pwdata); end
    step();
    // ENABLE
    vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL wr_en_hready got %b want 1", bus.Hreadyout); end
    vectors++; if (bus.Pselx !== 4'b0001) begin miscompares++; $display("FAIL wr_en_psel got %b want 0001", bus.Pselx); end
    vectors++; if (bus.Penable !== 1'b1) begin miscompares++; $display("FAIL wr_en_penable got %b want 1", bus.Penable); end
    vectors++; if (bus.Pwdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_en_pwdata got %h want deadbeef", bus.Pwdata); end
    step();
    // back in IDLE
    vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL wr_idle_psel got %b want 0000", bus.Pselx); end
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL wr_idle_penable got %b want 0", bus.Penable); end
  endtask

  task automatic test_single_read();
    addr_phase(32'h8800_0004, 1'b0, HTRANS_NONSEQ, 1'b1);
    step();
    // SETUP directly, no WWAIT for reads
    bus_idle();
    bus.Prdata = 32'h1234_5678;
    vectors++; if (bus.Hreadyout !== 1'b0) begin miscompares++; $display("FAIL rd_setup_hready got %b want 0", bus.Hreadyout); end
    vectors++; if (bus.Pselx !== 4'b0100) begin miscompares++; $display("FAIL rd_setup_psel got %b want 0100", bus.Pselx); end
    vectors++; if (bus.Pwrite !== 1'b0) begin miscompares++; $display("FAIL rd_setup_pwrite got %b want 0", bus.Pwrite); end
    step();
    // ENABLE
    vectors++; if (bus.Penable !== 1'b1) begin miscompares++; $display("FAIL rd_en_penable got %b want 1", bus.Penable); end
    vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL rd_en_hready got %b want 1", bus.Hreadyout); end
    vectors++; if (bus.Hrdata !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_en_hrdata got %h want 12345678", bus.Hrdata); end
    vectors++; if (bus.Paddr !== 32'h8800_0004) begin miscompares++; $display("FAIL rd_en_paddr got %h want 88000004", bus.Paddr); end
    step();
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL rd_idle_penable got %b want 0", bus.Penable); end
  endtask

  task automatic test_back_to_back();
    addr_phase(32'h8400_0000, 1'b0, HTRANS_NONSEQ, 1'b1);
    step();
    // SETUP of read
    bus_idle();
    bus.Prdata = 32'hA5A5_0001;
    vectors++; if (bus.Pselx !== 4'b0010) begin miscompares++; $display("FAIL b2b_rd_setup_psel got %b want 0010", bus.Pselx); end
    step();
    // ENABLE of read; next (write) address phase presented here
    vectors++; if (bus.Penable !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_en_penable got %b want 1", bus.Penable); end
    vectors++; if (bus.Hrdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL b2b_rd_en_hrdata got %h want a5a50001", bus.Hrdata); end
    addr_phase(32'h8C00_0000, 1'b1, HTRANS_NONSEQ, 1'b1);
    step();
    // WWAIT directly after ENABLE
    bus_idle();
    bus.Hwdata = 32'h0BAD_F00D;
    vectors++; if (bus.Hreadyout !== 1'b0) begin miscompares++; $display("FAIL b2b_wwait_hready got %b want 0", bus.Hreadyout); end
    vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL b2b_wwait_psel got %b want 0000", bus.Pselx); end
    vectors++; if (bus.Paddr !== 32'h8C00_0000) begin miscompares++; $display("FAIL b2b_wwait_paddr got %h want 8c000000", bus.Paddr); end
    step();
    vectors++; if (bus.Pselx !== 4'b1000) begin miscompares++; $display("FAIL b2b_wr_setup_psel got %b want 1000", bus.Pselx); end
    vectors++; if (bus.Pwdata !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL b2b_wr_setup_pwdata got %h want 0badf00d", bus.Pwdata); end
    step();
    vectors++; if (bus.Penable !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_en_penable got %b want 1", bus.Penable); end
    step();
  endtask

  task automatic test_filtering();
    addr_phase(32'h8000_0000, 1'b1, HTRANS_BUSY, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL flt_busy_psel cyc %0d got %b want 0000", i, bus.Pselx); end
      vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL flt_busy_hready cyc %0d got %b want 1", i, bus.Hreadyout); end
    end
    addr_phase(32'h9000_0000, 1'b0, HTRANS_NONSEQ, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL flt_range_psel cyc %0d got %b want 0000", i, bus.Pselx); end
      vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL flt_range_hready cyc %0d got %b want 1", i, bus.Hreadyout); end
    end
    // Rejected transfers must not disturb the last latched address.
    vectors++; if (bus.Paddr !== 32'h8C00_0000) begin miscompares++; $display("FAIL flt_paddr got %h want 8c000000", bus.Paddr); end
    bus_idle();
    step();
  endtask

  task automatic test_hreadyin_low();
    addr_phase(32'h8000_0040, 1'b0, HTRANS_NONSEQ, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL rdyin_psel cyc %0d got %b want 0000", i, bus.Pselx); end
      vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL rdyin_hready cyc %0d got %b want 1", i, bus.Hreadyout); end
    end
    bus_idle();
    step();
  endtask

  task automatic test_reset_in_enable();
    addr_phase(32'h8000_0020, 1'b1, HTRANS_NONSEQ, 1'b1);
    step();
    bus_idle();
    bus.Hwdata = 32'h55AA_55AA;
    step();
    step();
    vectors++; if (bus.Penable !== 1'b1) begin miscompares++; $display("FAIL rst_en_pre_penable got %b want 1", bus.Penable); end
    // Reset with a competing valid address phase: reset must win.
    Hreset = 1'b1;
    addr_phase(32'h8400_0000, 1'b0, HTRANS_NONSEQ, 1'b1);
    step();
    Hreset = 1'b0;
    bus_idle();
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL rst_en_penable got %b want 0", bus.Penable); end
    vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL rst_en_psel got %b want 0000", bus.Pselx); end
    vectors++; if (bus.Hreadyout !== 1'b1) begin miscompares++; $display("FAIL rst_en_hready got %b want 1", bus.Hreadyout); end
    vectors++; if (bus.Paddr !== 32'h0) begin miscompares++; $display("FAIL rst_en_paddr got %h want 0", bus.Paddr); end
    vectors++; if (bus.Pwdata !== 32'h0) begin miscompares++; $display("FAIL rst_en_pwdata got %h want 0", bus.Pwdata); end
    vectors++; if (bus.Pwrite !== 1'b0) begin miscompares++; $display("FAIL rst_en_pwrite got %b want 0", bus.Pwrite); end
    vectors++; if (bus.Hresp !== 2'b00) begin miscompares++; $display("FAIL rst_en_hresp got %b want 00", bus.Hresp); end
    step();
    vectors++; if (bus.Penable !== 1'b0) begin miscompares++; $display("FAIL rst_en_post_penable got %b want 0", bus.Penable); end
    vectors++; if (bus.Pselx !== 4'b0000) begin miscompares++; $display("FAIL rst_en_post_psel got %b want 0000", bus.Pselx); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Hreset      = 1'b1;
    bus_idle();
    bus.Hwdata  = 32'h0;
    bus.Prdata  = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_filtering();
    test_hreadyin_low();
    test_reset_in_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
